// File: rtl/conv_pkg.sv
// +----------------------------------------------------------------------------+
// | conv_pkg: shared state encoding and Q2.6 constants for the conv datapath   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package conv_pkg;

  localparam int TAPS_DEF  = 9;
  localparam int DW_DEF    = 9;
  localparam int FRAC_DEF  = 6;
  localparam int ACC_W_DEF = 16;

  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_LAST = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [8:0] Q_MAX = 9'h0FF;
  localparam logic [8:0] Q_MIN = 9'h100;
  localparam logic [8:0] Q_ONE = 9'h040;

endpackage

`default_nettype wire

// File: rtl/q26_mult.sv
// +----------------------------------------------------------------------------+
// | q26_mult: signed DW x DW multiply, floor-scaled by an arithmetic >>> FRAC  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module q26_mult
  import conv_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0]        a,
  input  logic signed [DW-1:0]        b,
  output logic signed [2*DW-FRAC-1:0] p
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;
  logic                   w_unused_sign;

  assign w_prod  = a * b;
  assign w_shift = w_prod >>> FRAC;
  assign p       = w_shift[2*DW-FRAC-1:0];

  // The top FRAC bits are pure sign copies after the shift.
  assign w_unused_sign = ^w_shift[2*DW-1:2*DW-FRAC];

endmodule

`default_nettype wire

// File: rtl/conv_mac_ctrl.sv
// +----------------------------------------------------------------------------+
// | conv_mac_ctrl: 3x3 conv MAC sequencer, one shared multiplier, Q2.6 result  |
// | Optional build macro: CONV_RELU_EN clamps negative results to zero.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_mac_ctrl
  import conv_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     rd_en,
  output logic [$clog2(TAPS)-1:0]  rd_addr,
  input  logic [DW-1:0]            rd_pix,
  input  logic [DW-1:0]            rd_wgt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data
);

  localparam int PW = 2*DW - FRAC;
  localparam int AW = $clog2(TAPS);

  localparam logic [AW-1:0]           c_last_tap = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] c_acc_max  = ACC_W'((2**(DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] c_acc_min  = ~c_acc_max;

  logic [ST_W-1:0]         r_state;
  logic [ST_W-1:0]         w_state_next;
  logic [AW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_rd_en_d;
  logic [DW-1:0]           r_out_data;

  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_acc_next;
  logic [DW-1:0]           w_sat;
  logic [DW-1:0]           w_result;
  logic                    w_hs;
  logic                    w_accept;

  q26_mult #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mult (
    .a (rd_pix),
    .b (rd_wgt),
    .p (w_prod)
  );

  assign w_hs       = (r_state == ST_OUT) && out_ready;
  assign w_accept   = start && ((r_state == ST_IDLE) || w_hs);
  assign w_acc_next = r_acc + {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  // Saturate the sum including the tap arriving this cycle.
  always_comb begin
    if (w_acc_next > c_acc_max) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
    end else if (w_acc_next < c_acc_min) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
    end else begin
      w_sat = w_acc_next[DW-1:0];
    end
  end

`ifdef CONV_RELU_EN
  assign w_result = w_sat[DW-1] ? '0 : w_sat;
`else
  assign w_result = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == c_last_tap) w_state_next = ST_LAST;
      ST_LAST: w_state_next = ST_OUT;
      ST_OUT:  if (out_ready) w_state_next = start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    case (r_state)
      ST_RUN: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = r_cnt;
      end
      ST_LAST: busy = 1'b1;
      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands land one cycle after rd_en, so accumulation follows the delayed strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rd_en_d  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_rd_en_d <= rd_en;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + AW'(1);
      end
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_rd_en_d) begin
        r_acc <= w_acc_next;
      end
      if (r_state == ST_LAST) begin
        r_out_data <= w_result;
      end
    end
  end

  assign out_data = r_out_data;

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_conv_mac_ctrl: directed and random checks of conv_mac_ctrl against an   |
// | arithmetic reference model. Revision: 1.0                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_conv_mac_ctrl;

  localparam int TAPS  = 9;
  localparam int DW    = 9;
  localparam int FRAC  = 6;
  localparam int ACC_W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          rd_en;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_pix = '0;
  logic [DW-1:0] rd_wgt = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;

  logic signed [DW-1:0] pix_mem [TAPS];
  logic signed [DW-1:0] wgt_mem [TAPS];

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] e;
  logic [DW-1:0] e2;
  logic [DW-1:0] neg_full;

  always #5 clk = ~clk;

  conv_mac_ctrl #(
    .TAPS  (TAPS),
    .DW    (DW),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_pix    (rd_pix),
    .rd_wgt    (rd_wgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Synchronous line/kernel buffer: one cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_pix <= pix_mem[rd_addr];
      rd_wgt <= wgt_mem[rd_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sum of floor(pix*wgt / 2^FRAC) over the taps, then clamp to Q2.6.
  function automatic logic [DW-1:0] model();
    int sum = 0;
    int prod;
    int q;
    logic [31:0] tmp;
    logic [DW-1:0] res;
    for (int i = 0; i < TAPS; i++) begin
      prod = int'(pix_mem[i]) * int'(wgt_mem[i]);
      q = prod / (1 << FRAC);
      if (prod < 0 && (prod % (1 << FRAC)) != 0) q = q - 1;
      sum += q;
    end
    tmp = sum;
    if (sum > 255) res = 9'h0FF;
    else if (sum < -256) res = 9'h100;
    else res = tmp[DW-1:0];
`ifdef CONV_RELU_EN
    if (sum < 0) res = '0;
`endif
    return res;
  endfunction

  task automatic load_const(input logic [DW-1:0] p, input logic [DW-1:0] w);
    for (int i = 0; i < TAPS; i++) begin
      pix_mem[i] = p;
      wgt_mem[i] = w;
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < TAPS; i++) begin
      pix_mem[i] = DW'($urandom_range(0, 511));
      wgt_mem[i] = DW'($urandom_range(0, 511));
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    check("idle_before_start", busy, 1'b0);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the negedge following acceptance; leaves at the negedge after out_valid rises.
  task automatic run_body(input logic [DW-1:0] exp);
    check("busy_run", busy, 1'b1);
    for (int k = 0; k < TAPS; k++) begin
      if (k > 0) @(negedge clk);
      check("rd_en_run", rd_en, 1'b1);
      check("rd_addr", rd_addr, k);
      check("no_valid_run", out_valid, 1'b0);
    end
    @(negedge clk);
    check("rd_en_last", rd_en, 1'b0);
    check("no_valid_last", out_valid, 1'b0);
    @(negedge clk);
    check("valid_rise", out_valid, 1'b1);
    check("out_data", out_data, exp);
  endtask

  task automatic finish_op(input logic [DW-1:0] exp, input int hold, input bit next_start);
    for (int i = 0; i < hold; i++) begin
      start = (i % 2 == 0);
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, exp);
      check("hold_busy", busy, 1'b1);
      check("hold_no_rd", rd_en, 1'b0);
    end
    start = next_start;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    if (next_start) begin
      check("b2b_rd_en", rd_en, 1'b1);
      check("b2b_addr", rd_addr, 0);
      check("b2b_valid", out_valid, 1'b0);
    end else begin
      check("done_busy", busy, 1'b0);
      check("done_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
`ifdef CONV_RELU_EN
    neg_full = 9'h000;
`else
    neg_full = 9'h100;
`endif
    load_const(9'h000, 9'h000);

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;

    load_const(9'h020, 9'h010);
    do_start();
    run_body(9'h048);
    finish_op(9'h048, 0, 1'b0);

    load_const(9'h040, 9'h040);
    do_start();
    run_body(9'h0FF);
    finish_op(9'h0FF, 1, 1'b0);

    load_const(9'h040, 9'h1C0);
    do_start();
    run_body(neg_full);
    finish_op(neg_full, 0, 1'b0);

    // Stalled output with start ignored, then start and handshake together.
    load_const(9'h1FF, 9'h020);
    do_start();
    run_body(9'h1F7);
    load_rand();
    e2 = model();
    finish_op(9'h1F7, 5, 1'b1);
    run_body(e2);
    finish_op(e2, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      load_rand();
      e = model();
      do_start();
      run_body(e);
      finish_op(e, $urandom_range(0, 3), 1'b0);
    end

    load_rand();
    e = model();
    do_start();
    for (int n = 0; n < 4; n++) begin
      run_body(e);
      load_rand();
      e2 = model();
      finish_op(e, 0, 1'b1);
      e = e2;
    end
    run_body(e);
    finish_op(e, 0, 1'b0);

    // Abort mid-run at tap 4.
    load_const(9'h040, 9'h040);
    do_start();
    repeat (4) @(negedge clk);
    check("abort_addr", rd_addr, 4);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_rd_en", rd_en, 1'b0);
    check("abort_rd_addr", rd_addr, 0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end

    load_rand();
    e = model();
    do_start();
    run_body(e);
    finish_op(e, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
